// File: rtl/assoc_dcache_pkg.sv
// Shared types and helpers for the set-associative data cache.
// FSM encoding, address split helpers and the true-LRU age update.
package assoc_dcache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_REFILL,
    S_RESP
  } state_t;

  localparam int unsigned MAX_WAYS  = 4;
  localparam int unsigned AGE_MAX_W = 2;

  typedef logic [MAX_WAYS*AGE_MAX_W-1:0] age_vec_t;

  function automatic logic [63:0] addr_off(
    input logic [63:0] a,
    input int unsigned off_w
  );
    return (a >> 2) & ((64'd1 << off_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_idx(
    input logic [63:0] a,
    input int unsigned off_w,
    input int unsigned idx_w
  );
    return (a >> (off_w + 2)) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(
    input logic [63:0] a,
    input int unsigned off_w,
    input int unsigned idx_w
  );
    return a >> (off_w + idx_w + 2);
  endfunction

  // Touched way goes to age 0; every way younger than it ages by one.
  function automatic age_vec_t lru_touch(
    input age_vec_t    ages,
    input logic [1:0]  way,
    input int unsigned nways
  );
    age_vec_t   r;
    logic [1:0] old;
    logic [1:0] a;
    r   = ages;
    old = ages[32'(way)*AGE_MAX_W +: AGE_MAX_W];
    for (int unsigned i = 0; i < MAX_WAYS; i++) begin
      a = ages[i*AGE_MAX_W +: AGE_MAX_W];
      if (i < nways) begin
        if (i == 32'(way))
          r[i*AGE_MAX_W +: AGE_MAX_W] = '0;
        else if (a < old)
          r[i*AGE_MAX_W +: AGE_MAX_W] = a + 2'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set true-LRU ages, hit update and victim selection.
// WAYS=1 collapses to a constant victim of way 0.
module dcache_lru
  import assoc_dcache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic             touch,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [WAYS-1:0]  valid_set,
  output logic [WAY_W-1:0] victim
);

  generate
    if (WAYS == 1) begin : g_dm
      logic unused;
      assign unused = ^{clk, rst, idx, touch,
                        touch_way, valid_set};
      assign victim = '0;
    end else begin : g_lru
      localparam int AW = $clog2(WAYS);

      logic [AW-1:0] age_q [SETS][WAYS];
      age_vec_t      cur;
      age_vec_t      nxt;
      logic          found;

      always_comb begin
        cur = '0;
        for (int w = 0; w < WAYS; w++)
          cur[w*AGE_MAX_W +: AGE_MAX_W] =
            AGE_MAX_W'(age_q[idx][w]);
        nxt = lru_touch(cur, 2'(touch_way), WAYS);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              age_q[s][w] <= AW'(w);
        end else if (touch) begin
          for (int w = 0; w < WAYS; w++)
            age_q[idx][w] <= AW'(nxt[w*AGE_MAX_W +: AGE_MAX_W]);
        end
      end

      // Lowest invalid way first, otherwise the oldest way.
      always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          if (!valid_set[w] && !found) begin
            victim = WAY_W'(w);
            found  = 1'b1;
          end
        end
        if (!found) begin
          for (int w = 0; w < WAYS; w++)
            if (age_q[idx][w] == AW'(WAYS - 1))
              victim = WAY_W'(w);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/assoc_data_cache.sv
// N-way write-back, write-allocate data cache with true-LRU.
// Optional hit/miss counters under ASSOC_DCACHE_STATS_EN.
module assoc_data_cache
  import assoc_dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         r0w1,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            din,
  output logic                         rdy,
  output logic [DATA_W-1:0]            dout,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [LINE_WORDS*DATA_W-1:0] mem_wdata,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_rdata,
  input  logic                         mem_ack
`ifdef ASSOC_DCACHE_STATS_EN
  ,
  output logic [31:0]                  hit_cnt,
  output logic [31:0]                  miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W - 2;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = LINE_WORDS * DATA_W;

  state_t state_q, state_d;

  logic [ADDR_W-1:2] req_a_q;
  logic [DATA_W-1:0] req_din_q;
  logic              req_we_q;
  logic [WAY_W-1:0]  victim_q;
  logic [DATA_W-1:0] dout_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  logic [63:0]       req_full;
  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  assign req_full = 64'({req_a_q, 2'b00});
  assign req_off  = OFF_W'(addr_off(req_full, OFF_W));
  assign req_idx  = IDX_W'(addr_idx(req_full, OFF_W, IDX_W));
  assign req_tag  = TAG_W'(addr_tag(req_full, OFF_W, IDX_W));

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [LINE_W-1:0] hit_line;
  logic [DATA_W-1:0] hit_word;
  logic [WAY_W-1:0]  lru_victim;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && !hit &&
          tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    hit_line = data_q[req_idx][hit_way];
    hit_word = hit_line[int'(req_off)*DATA_W +: DATA_W];
  end

  logic cmp, do_hit, do_miss, rf_done;

  assign cmp     = (state_q == S_COMPARE);
  assign do_hit  = cmp && hit;
  assign do_miss = cmp && !hit;
  assign rf_done = (state_q == S_REFILL) && mem_ack;

  dcache_lru #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .WAY_W (WAY_W)
  ) u_lru (
    .clk       (clk),
    .rst       (rst),
    .idx       (req_idx),
    .touch     (do_hit),
    .touch_way (hit_way),
    .valid_set (valid_q[req_idx]),
    .victim    (lru_victim)
  );

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE:
        if (en) state_d = S_COMPARE;
      S_COMPARE: begin
        if (hit)
          state_d = S_RESP;
        else if (valid_q[req_idx][lru_victim] &&
                 dirty_q[req_idx][lru_victim])
          state_d = S_WRITEBACK;
        else
          state_d = S_REFILL;
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_idx][victim_q], req_idx,
                     {(OFF_W+2){1'b0}}};
        mem_wdata = data_q[req_idx][victim_q];
        if (mem_ack) state_d = S_REFILL;
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
        if (mem_ack) state_d = S_COMPARE;
      end
      S_RESP:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_a_q   <= '0;
      req_din_q <= '0;
      req_we_q  <= 1'b0;
      victim_q  <= '0;
      dout_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && en) begin
        req_a_q   <= addr[ADDR_W-1:2];
        req_din_q <= din;
        req_we_q  <= r0w1;
      end
      if (do_miss)
        victim_q <= lru_victim;
      if (do_hit && !req_we_q)
        dout_q <= hit_word;
      if (do_hit && req_we_q)
        dirty_q[req_idx][hit_way] <= 1'b1;
      if (rf_done) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (rf_done) begin
        data_q[req_idx][victim_q] <= mem_rdata;
        tag_q[req_idx][victim_q]  <= req_tag;
      end
      if (do_hit && req_we_q)
        data_q[req_idx][hit_way][int'(req_off)*DATA_W +: DATA_W]
          <= req_din_q;
    end
  end

  assign rdy  = (state_q == S_RESP);
  assign dout = dout_q;

`ifdef ASSOC_DCACHE_STATS_EN
  logic refilled_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      refilled_q <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      if (state_q == S_IDLE)
        refilled_q <= 1'b0;
      else if (rf_done)
        refilled_q <= 1'b1;
      if (cmp && !refilled_q) begin
        if (hit) hit_cnt  <= hit_cnt + 32'd1;
        else     miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`else
  // Without counters the post-refill re-compare needs no tracking.
`endif

endmodule

// File: tb/tb_assoc_data_cache.sv
// Directed bench for assoc_data_cache with a backing-memory model
// and queued expectations for read data and memory transactions.
module tb_assoc_data_cache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         r0w1 = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  din = '0;
  logic         rdy;
  logic [31:0]  dout;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;
`ifdef ASSOC_DCACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  assoc_data_cache dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .r0w1      (r0w1),
    .addr      (addr),
    .din       (din),
    .rdy       (rdy),
    .dout      (dout),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef ASSOC_DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         we;
    logic [31:0]  a;
    logic [127:0] d;
  } memx_t;

  memx_t        exp_mem[$];
  logic [31:0]  exp_rd[$];
  logic [31:0]  wr_ref    [logic [31:0]];
  logic [127:0] mem_store [logic [31:0]];
  bit           hold_ack = 1'b0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'h10 + (a >> 2);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (wr_ref.exists(a)) return wr_ref[a];
    return pat(a);
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] la);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = ref_word(la + 32'(4*i));
    return l;
  endfunction

  function automatic logic [127:0] store_line(input logic [31:0] la);
    logic [127:0] l;
    if (mem_store.exists(la)) return mem_store[la];
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = pat(la + 32'(4*i));
    return l;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing memory: random 0..2 cycle ack delay per transaction.
  initial begin : responder
    int    wait_cnt;
    memx_t e;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst || !mem_req || hold_ack) begin
        wait_cnt = $urandom_range(0, 2);
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        if (exp_mem.size() == 0) begin
          chk("spurious mem_req", {127'b0, mem_req}, 128'd0);
          mem_rdata = store_line(mem_addr);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_we", {127'b0, mem_we}, {127'b0, e.we});
          chk("mem_addr", {96'b0, mem_addr}, {96'b0, e.a});
          if (e.we) begin
            chk("mem_wdata", mem_wdata, e.d);
            mem_store[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = store_line(mem_addr);
          end
        end
        mem_ack  = 1'b1;
        wait_cnt = $urandom_range(0, 2);
      end
    end
  end

  task automatic do_req(input bit we, input logic [31:0] a,
                        input logic [31:0] d, input int lat);
    int n;
    bit got;
    @(negedge clk);
    en   = 1'b1;
    r0w1 = we;
    addr = a;
    din  = d;
    if (we) wr_ref[a] = d;
    else    exp_rd.push_back(ref_word(a));
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      got = rdy;
    end
    en = 1'b0;
    chk("rdy arrives", {127'b0, got}, 128'd1);
    if (got && lat > 0) chk("hit latency", 128'(n), 128'(lat));
    if (!we && got)
      chk("dout", {96'b0, dout}, {96'b0, exp_rd.pop_front()});
    @(posedge clk);
    #1;
    chk("rdy single pulse", {127'b0, rdy}, 128'd0);
  endtask

  task automatic exp_refill(input logic [31:0] la);
    exp_mem.push_back('{we: 1'b0, a: la, d: '0});
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rdy", {127'b0, rdy}, 128'd0);
    chk("reset dout", {96'b0, dout}, 128'd0);
    chk("reset mem_req", {127'b0, mem_req}, 128'd0);
    chk("reset mem_we", {127'b0, mem_we}, 128'd0);
    chk("reset mem_addr", {96'b0, mem_addr}, 128'd0);
    chk("reset mem_wdata", mem_wdata, 128'd0);
    rst = 1'b0;

    exp_refill(32'h000);
    do_req(1'b0, 32'h004, '0, 0);
    chk("first refill done", 128'(exp_mem.size()), 128'd0);

    do_req(1'b1, 32'h004, 32'h5a5a5a5a, 2);
    do_req(1'b0, 32'h004, '0, 2);

    exp_refill(32'h100);
    do_req(1'b0, 32'h104, '0, 0);
    exp_mem.push_back('{we: 1'b1, a: 32'h000, d: ref_line(32'h000)});
    exp_refill(32'h200);
    do_req(1'b0, 32'h204, '0, 0);
    chk("evict traffic done", 128'(exp_mem.size()), 128'd0);
`ifdef ASSOC_DCACHE_STATS_EN
    chk("hit_cnt", {96'b0, hit_cnt}, 128'd2);
    chk("miss_cnt", {96'b0, miss_cnt}, 128'd3);
`endif

    exp_refill(32'h080);
    do_req(1'b0, 32'h084, '0, 0);
    do_req(1'b0, 32'h104, '0, 2);
    do_req(1'b0, 32'h204, '0, 2);
    chk("set8 traffic done", 128'(exp_mem.size()), 128'd0);

    hold_ack = 1'b1;
    @(negedge clk);
    en   = 1'b1;
    r0w1 = 1'b0;
    addr = 32'h304;
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("abort refill req", {127'b0, mem_req}, 128'd1);
    chk("abort refill we", {127'b0, mem_we}, 128'd0);
    chk("abort refill addr", {96'b0, mem_addr}, 128'h300);
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    #1;
    chk("mem_req drops on rst", {127'b0, mem_req}, 128'd0);
    chk("rdy low on rst", {127'b0, rdy}, 128'd0);
    @(negedge clk);
    rst      = 1'b0;
    hold_ack = 1'b0;

    exp_refill(32'h100);
    do_req(1'b0, 32'h104, '0, 0);
    chk("post-reset miss", 128'(exp_mem.size()), 128'd0);
`ifdef ASSOC_DCACHE_STATS_EN
    chk("hit_cnt after rst", {96'b0, hit_cnt}, 128'd0);
    chk("miss_cnt after rst", {96'b0, miss_cnt}, 128'd1);
`endif

    repeat (4) @(negedge clk);
    chk("read queue drained", 128'(exp_rd.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_data_cache.md
Name: assoc_data_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement.
- Sits between the CPU memory stage and a line-wide backing memory port.
- Keeps the existing single-word CPU handshake (en/r0w1/addr/din -> rdy/dout).
- Adds associativity, configurable geometry, a dirty-line write-back path and a refill handshake.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, CPU word width; fixed at 32 in this generation, byte offset is 2 bits.
- WAYS, 2, associativity; power of 2, 1..4.
- SETS, 16, number of sets; power of 2, >= 2.
- LINE_WORDS, 4, words per line; power of 2, >= 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  CPU request valid; held high with addr/din/r0w1 stable until rdy.
- r0w1  in  1  0 = read, 1 = write.
- addr  in  ADDR_W  byte address; bits [1:0] ignored.
- din  in  DATA_W  write data.
- rdy  out  1  one-cycle completion pulse.
- dout  out  DATA_W  read data; registered, held until next read completes.
- mem_req  out  1  backing-memory request; held until mem_ack.
- mem_we  out  1  1 = line write-back, 0 = line refill.
- mem_addr  out  ADDR_W  line-aligned address; low OFF+2 bits are 0.
- mem_wdata  out  LINE_WORDS*DATA_W  victim line; word 0 in the LSBs.
- mem_rdata  in  LINE_WORDS*DATA_W  refill line; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle acknowledge for the current mem_req.

Behaviour:
- Address split (OFF = log2 LINE_WORDS, IDX = log2 SETS):
  - word offset = addr[OFF+1:2]
  - index = addr[OFF+IDX+1:OFF+2]
  - tag = remaining upper bits
- Per line storage: valid, dirty, tag, data. Per set: LRU age, log2(WAYS) bits per way; 0 = most recent.
- Reset: all valid and dirty bits cleared in one cycle; ages set to way index; FSM goes to IDLE.
  - Output reset values: rdy=0, dout=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation aborts any memory transaction; mem_req drops at the same edge.
- FSM states: IDLE, COMPARE, WRITEBACK, REFILL, RESP.
  - IDLE: en=1 -> latch addr, din, r0w1 -> COMPARE.
  - COMPARE, hit:
    - Read: dout <= word.
    - Write: word <= din, dirty <= 1.
    - Hit way becomes age 0; ages younger than its old age increment.
    - -> RESP.
  - COMPARE, miss: victim = invalid way with the lowest index; if none, the way with the maximum age.
    - Victim valid and dirty -> WRITEBACK.
    - Otherwise -> REFILL.
  - WRITEBACK: mem_req=1, mem_we=1, mem_addr = victim tag|index, mem_wdata = victim line. mem_ack -> REFILL.
  - REFILL: mem_req=1, mem_we=0, mem_addr = request line. On mem_ack: line <= mem_rdata, valid=1, dirty=0, tag updated -> COMPARE, which re-checks and now hits.
  - RESP: rdy=1 for exactly one cycle -> IDLE. A held en is not re-sampled until IDLE.
- Latency:
  - Hit: rdy 2 cycles after the IDLE sampling edge; back-to-back hits every 3 cycles.
  - Clean miss: hit latency + refill wait + 1.
- mem_ack outside WRITEBACK/REFILL is ignored.
- mem_ack in the same cycle mem_req first rises is legal.
- WAYS=1 degenerates to direct-mapped; the age logic is a constant.

Optional Feature:
- Macro: ASSOC_DCACHE_STATS_EN.
- Defined:
  - Adds output ports hit_cnt and miss_cnt, each 32 bits.
  - Incremented on the COMPARE-state evaluation of each original request.
  - The re-compare after refill counts as neither.
  - Both counters clear on rst and wrap at 2^32.
- Undefined: ports and counters absent; function otherwise identical.

Decomposition:
- Package assoc_dcache_pkg:
  - FSM state encoding.
  - Helper functions for the offset/index/tag split.
  - The LRU age-update function.
- One natural sub-module: dcache_lru, holding the per-set age array, hit update and victim select.
- Tag/data arrays and the FSM stay in the top.

Test Plan:
- Defaults. Reset, then read 0x004 with the memory model returning line {0x13,0x12,0x11,0x10} -> one refill at mem_addr 0x000, no write-back, rdy with dout = 0x11.
- Write 0x5a5a5a5a to 0x004, then read 0x004 -> both hit with no mem_req; dout = 0x5a5a5a5a.
- Read 0x104, then read 0x204 (all index 0) -> refill 0x100, then a write-back of line 0x000 with word1 = 0x5a5a5a5a, then refill 0x200.
- Read 0x084 (index 8) -> independent set, clean refill at 0x080, index 0 contents untouched.
- Assert rst during REFILL before mem_ack -> mem_req=0 next cycle; a following read of 0x104 misses.
- With ASSOC_DCACHE_STATS_EN, after the first three scenarios -> hit_cnt = 2, miss_cnt = 3.
